// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage of the RV32 core. Owns the program counter, presents
// it to a combinational instruction ROM, and captures each fetched word and its
// PC into the IF/ID output register. A valid/ready handshake connects it to
// decode. Jumps redirect the PC and flush the output register. A debug halt
// stops fetching. A counter tracks the instructions that decode has accepted.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   rom_addr_o   word-aligned fetch address (the current PC)
//   rom_inst_i   ROM word for rom_addr_o, same cycle
//   jump_en_i    redirect request from execute
//   jump_addr_i  redirect target
//   halt_i       level-sensitive debug halt request
//   id_ready_i   decode accepts the output register this cycle
//   if_valid_o   output register holds a live instruction
//   if_inst_o    registered instruction (NOP when not valid)
//   if_pc_o      PC of if_inst_o
//   misalign_o   one-cycle pulse when a jump target was not word aligned
//   halted_o     high while halted
//   fetch_cnt_o  number of instructions accepted by decode
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        halt_i,
    input  logic        id_ready_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        misalign_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        misalign_q, misalign_d;
    logic        halted_q, halted_d;
    logic [31:0] cnt_q, cnt_d;

    logic        free_s;
    logic        take_s;
    logic        fetch_s;

    // Handshake qualifiers shared by the datapath and the counter
    always_comb begin
        free_s  = !valid_q || id_ready_i;
        // A valid&&ready that coincides with a jump is a squash, not a take
        take_s  = valid_q && id_ready_i && !jump_en_i;
        fetch_s = (state_q == S_RUN) && !halt_i && !jump_en_i && free_s;
    end

    // Next-state logic; a jump leaves the state untouched
    always_comb begin
        state_d = state_q;
        if (jump_en_i) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_BOOT:  state_d = halt_i ? S_HALT : S_RUN;
                S_RUN:   state_d = halt_i ? S_HALT : S_RUN;
                S_HALT:  state_d = halt_i ? S_HALT : S_RUN;
                default: state_d = S_BOOT;
            endcase
        end
        halted_d = (state_d == S_HALT);
    end

    // PC, output register, misalign pulse and counter next values
    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        ipc_d      = ipc_q;
        misalign_d = 1'b0;
        cnt_d      = take_s ? (cnt_q + 32'd1) : cnt_q;
        if (jump_en_i) begin
            // Flush: the output PC is deliberately left as it was
            pc_d       = {jump_addr_i[31:2], 2'b00};
            valid_d    = 1'b0;
            inst_d     = INST_NOP;
            misalign_d = |jump_addr_i[1:0];
        end else if (fetch_s) begin
            inst_d  = rom_inst_i;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (take_s) begin
            // Consumed while halting/halted: drain to a bubble
            valid_d = 1'b0;
            inst_d  = INST_NOP;
        end else begin
            // Stall or idle: everything holds
            pc_d = pc_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            inst_q     <= INST_NOP;
            ipc_q      <= RESET_PC;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            ipc_q      <= ipc_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rom_addr_o  = pc_q;
    assign if_valid_o  = valid_q;
    assign if_inst_o   = inst_q;
    assign if_pc_o     = ipc_q;
    assign misalign_o  = misalign_q;
    assign halted_o    = halted_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed, table-driven bench for if_fetch_unit. Each record holds the inputs
// for one clock edge and the outputs expected just after that edge. The ROM is
// modelled as word(a) = (a << 5) | 0x13, so 0->0x13, 4->0x93, 8->0x113.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        halt;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        misalign;
    logic        halted;
    logic [31:0] fetch_cnt;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic        rst;
        logic        jmp;
        logic [31:0] jaddr;
        logic        halt;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_mis;
        logic        e_halted;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .INST_NOP(32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr_o  (rom_addr),
        .rom_inst_i  (rom_inst),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .halt_i      (halt),
        .id_ready_i  (id_ready),
        .if_valid_o  (if_valid),
        .if_inst_o   (if_inst),
        .if_pc_o     (if_pc),
        .misalign_o  (misalign),
        .halted_o    (halted),
        .fetch_cnt_o (fetch_cnt)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a << 5) | 32'h0000_0013;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic r, input logic j, input logic [31:0] ja,
                       input logic h, input logic rd, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep,
                       input logic [31:0] ea, input logic em, input logic eh,
                       input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.jmp = j; v.jaddr = ja; v.halt = h; v.rdy = rd;
        v.e_valid = ev; v.e_inst = ei; v.e_pc = ep; v.e_addr = ea;
        v.e_mis = em; v.e_halted = eh; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1; jump_en = 1'b0; jump_addr = 32'd0; halt = 1'b0; id_ready = 1'b1;

        //   rst   jmp   jaddr          halt  rdy  | valid inst           pc             addr           mis   halted cnt
        add(1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0); // 0 reset
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0); // 1 boot: no fetch
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0,         32'h4,         1'b0, 1'b0, 32'd0); // 2 pc0
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0093, 32'h4,         32'h8,         1'b0, 1'b0, 32'd1); // 3 pc4
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0113, 32'h8,         32'hC,         1'b0, 1'b0, 32'd2); // 4 pc8
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0193, 32'hC,         32'h10,        1'b0, 1'b0, 32'd3); // 5 cnt=3
        add(1'b0, 1'b1, 32'h4,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'hC,         32'h4,         1'b0, 1'b0, 32'd3); // 6 squash jump
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0093, 32'h4,         32'h8,         1'b0, 1'b0, 32'd3); // 7
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0093, 32'h4,         32'h8,         1'b0, 1'b0, 32'd3); // 8 stall
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0093, 32'h4,         32'h8,         1'b0, 1'b0, 32'd3); // 9 stall
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0093, 32'h4,         32'h8,         1'b0, 1'b0, 32'd3); // 10 stall
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0113, 32'h8,         32'hC,         1'b0, 1'b0, 32'd4); // 11 resume pc8
        add(1'b0, 1'b1, 32'h40,         1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h8,         32'h40,        1'b0, 1'b0, 32'd4); // 12 flush
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0813, 32'h40,        32'h44,        1'b0, 1'b0, 32'd4); // 13 pc 0x40
        add(1'b0, 1'b1, 32'h42,         1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h40,        1'b1, 1'b0, 32'd4); // 14 misaligned
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0813, 32'h40,        32'h44,        1'b0, 1'b0, 32'd4); // 15 pulse ends
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h44,        1'b0, 1'b1, 32'd5); // 16 halt: drain
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h44,        1'b0, 1'b1, 32'd5); // 17
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h44,        1'b0, 1'b1, 32'd5); // 18
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h44,        1'b0, 1'b1, 32'd5); // 19
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h40,        32'h44,        1'b0, 1'b0, 32'd5); // 20 back to run
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0893, 32'h44,        32'h48,        1'b0, 1'b0, 32'd5); // 21 pc 0x44
        add(1'b0, 1'b1, 32'hFFFF_FFFC,  1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h44,        32'hFFFF_FFFC, 1'b0, 1'b0, 32'd5); // 22
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'hFFFF_FF93, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b0, 32'd5); // 23 wrap
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h0,         32'h4,         1'b0, 1'b0, 32'd6); // 24
        add(1'b1, 1'b1, 32'h80,         1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0); // 25 rst beats jump
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b0, 1'b0, 32'd0); // 26 boot
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h4,         1'b0, 1'b0, 32'd0); // 27
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h0,         32'h4,         1'b0, 1'b1, 32'd0); // 28 halt, held
        add(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h4,         1'b0, 1'b1, 32'd1); // 29 taken once
        add(1'b0, 1'b1, 32'h100,        1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h100,       1'b0, 1'b1, 32'd1); // 30 jump while halted
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'h100,       1'b0, 1'b0, 32'd1); // 31
        add(1'b0, 1'b0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0000_2013, 32'h100,       32'h104,       1'b0, 1'b0, 32'd1); // 32

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            jump_en   = vecs[i].jmp;
            jump_addr = vecs[i].jaddr;
            halt      = vecs[i].halt;
            id_ready  = vecs[i].rdy;
            @(posedge clk);
            #1;
            total_cnt++;
            if (if_valid === vecs[i].e_valid && if_inst === vecs[i].e_inst &&
                if_pc === vecs[i].e_pc && rom_addr === vecs[i].e_addr &&
                misalign === vecs[i].e_mis && halted === vecs[i].e_halted &&
                fetch_cnt === vecs[i].e_cnt) begin
                pass_cnt++;
            end else begin
                $display("FAIL vec%0d: got valid=%0b inst=%h pc=%h addr=%h mis=%0b halted=%0b cnt=%h expected valid=%0b inst=%h pc=%h addr=%h mis=%0b halted=%0b cnt=%h",
                         i, if_valid, if_inst, if_pc, rom_addr, misalign, halted, fetch_cnt,
                         vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_addr,
                         vecs[i].e_mis, vecs[i].e_halted, vecs[i].e_cnt);
            end
        end

        // Counter wrap: preload the count, then one take must roll it to zero
        jump_en  = 1'b0;
        halt     = 1'b0;
        id_ready = 1'b1;
        dut.cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        check32("cnt_wrap", fetch_cnt, 32'h0000_0000);
        check32("pc_after_wrap_take", if_pc, 32'h0000_0104);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
